execute_stage: RTL and testbench
================================

# execute_stage

Execute stage of the MZNM pipeline, directly downstream of the decode/execute buffer. Each cycle it takes the latched operands, opcode and register addresses, performs the ALU operation, and updates the condition-code register (Z, N, C). It applies branch-shadow squashing from the flush count and presents a registered result bundle to the execute/memory buffer.

## Interface
- `W`, default 16: ALU data width. Operand ports are W+1 bits wide; the MSB is the decode "immediate present" tag.
- `Clk` in 1: single clock. All state updates on the rising edge.
- `RstN` in 1: reset, asynchronous, active-low.
- `Stall` in 1: hazard stall. When high, all state and outputs hold.
- `Reg1` in W+1: source operand 1 (Rsrc).
- `Reg2` in W+1: source operand 2 or immediate.
- `Instruction` in 5: opcode.
- `SrcAddress` in 3: source register index.
- `RegDestination` in 3: destination register index.
- `FlashNumIn` in 3: number of following instructions to squash. Nonzero only on a taken branch.
- `Result` out W: ALU result.
- `RegDestOut` out 3: destination register index, passed through.
- `SrcAddressOut` out 3: source register index, passed through for forwarding.
- `WriteEn` out 1: register-file write enable for the result.
- `Flags` out 3: CCR as {C, N, Z}.
- `Squashing` out 1: high while the flush counter is nonzero.

## Operation
- Opcode map:
  - 0 NOP
  - 1 SETC
  - 2 CLRC
  - 3 NOT
  - 4 INC
  - 5 DEC
  - 6 MOV
  - 7 ADD
  - 8 SUB
  - 9 AND
  - 10 OR
  - 11 SHL
  - 12 SHR
  - 13 LDM
  - 14–31 behave as NOP.
- Operands: A = Reg1[W-1:0], B = Reg2[W-1:0]. Bit W is ignored by the ALU.
- Results by opcode:
  - NOT: ~A.
  - INC: A+1.
  - DEC: A−1.
  - MOV: A.
  - ADD: A+B.
  - SUB: A−B.
  - AND: A&B.
  - OR: A|B.
  - SHL: A<<B[3:0].
  - SHR: A>>B[3:0] (logical).
  - LDM: B.
- WriteEn = 1 for opcodes 3–13; WriteEn = 0 otherwise.
- Z and N are updated from Result for opcodes 3–5 and 7–12. MOV and LDM leave all flags unchanged.
- C update rules:
  - ADD and INC: carry out of bit W-1.
  - SUB and DEC: borrow (C = 1 when A < subtrahend).
  - SHL: the last bit shifted out, A[W-B].
  - SHR: A[B-1].
  - A shift by 0 leaves C unchanged.
  - SETC sets C to 1; CLRC clears C to 0.
  - NOT, AND and OR leave C unchanged.
- Arithmetic is modulo 2^W.
- Flush counter (3 bits):
  - When the counter is 0 and `FlashNumIn` ≠ 0, load FlashNumIn. The instruction carrying FlashNumIn executes normally.
  - When the counter is nonzero, the incoming instruction is squashed and the counter decrements.
  - `FlashNumIn` arriving while the counter is nonzero is ignored (no reload).
- A squashed instruction produces WriteEn = 0 and leaves flags unchanged. Result, RegDestOut and SrcAddressOut still register their normal values.
- Stall has priority over everything: outputs, CCR and the counter all hold.

## Timing
- Inputs are sampled on the rising edge of `Clk` (upstream drives them from the falling edge).
- Result, RegDestOut, SrcAddressOut, WriteEn and Flags are registered. Latency is 1 cycle from the sampling edge.
- Flags reflect the instruction sampled at the previous edge. A flag-reading instruction that immediately follows sees the updated value in the same cycle through `Flags`.
- Squashing is the registered counter≠0 status. It asserts in the cycle after the FlashNum load and stays high for exactly FlashNumIn cycles, excluding stalled cycles.
- Reset (RstN low, asynchronous) values:
  - Result = 0, RegDestOut = 0, SrcAddressOut = 0, WriteEn = 0.
  - Flags = 000, counter = 0, Squashing = 0.
- Reset asserted mid-squash clears the counter. The first instruction after reset release executes.

## Structure
- Shared package `mznm_pkg` holds:
  - Opcode localparams (`OP_NOP` … `OP_LDM`).
  - Flag bit indices (`FLG_Z` = 0, `FLG_N` = 1, `FLG_C` = 2).
- Sub-module `alu`: purely combinational, computing result, carry-valid and carry-value from opcode, A and B.
- `execute_stage` holds the CCR, the flush counter and the output registers.

## Test plan
- Reset, then ADD with Reg1 = 0xFFFF and Reg2 = 0x0001 → next cycle Result = 0x0000, Z = 1, C = 1, N = 0, WriteEn = 1.
- SUB with A = 3, B = 5 → Result = 0xFFFE, N = 1, C = 1, Z = 0. Then MOV with A = 0 → Z still 0 (flags unchanged).
- SHL with A = 0x8001, B = 1 → Result = 0x0002, C = 1. SHR with A = 0x0001, B = 0 → Result = 0x0001, C unchanged.
- Branch with FlashNumIn = 2, followed by ADD, ADD, INC → branch executes; both ADDs give WriteEn = 0 with flags unchanged; INC executes; Squashing high for exactly 2 cycles.
- Stall held for 3 cycles during a squash with counter = 1 → outputs, flags and counter frozen; counter resumes after Stall drops; FlashNumIn = 3 arriving during the squash is ignored.
- RstN pulsed low asynchronously between edges while counter = 2 → all outputs 0 immediately; the first post-reset INC with A = 7 gives Result = 8, WriteEn = 1.

Source files
------------

// File: rtl/mznm_pkg.sv
// -----------------------------------------------------------------------------
// mznm_pkg
// Shared definitions for the MZNM execute stage:
//   - opcode encodings (5-bit opcode field; 14..31 behave as NOP)
//   - condition-code register bit positions inside Flags = {C, N, Z}
//   - small decode helpers shared by the stage and its ALU
// -----------------------------------------------------------------------------
package mznm_pkg;

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_SETC = 5'd1;
  localparam logic [4:0] OP_CLRC = 5'd2;
  localparam logic [4:0] OP_NOT  = 5'd3;
  localparam logic [4:0] OP_INC  = 5'd4;
  localparam logic [4:0] OP_DEC  = 5'd5;
  localparam logic [4:0] OP_MOV  = 5'd6;
  localparam logic [4:0] OP_ADD  = 5'd7;
  localparam logic [4:0] OP_SUB  = 5'd8;
  localparam logic [4:0] OP_AND  = 5'd9;
  localparam logic [4:0] OP_OR   = 5'd10;
  localparam logic [4:0] OP_SHL  = 5'd11;
  localparam logic [4:0] OP_SHR  = 5'd12;
  localparam logic [4:0] OP_LDM  = 5'd13;

  // Bit positions in the 3-bit CCR
  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_C = 2;

  // Opcodes NOT..LDM produce a register-file write
  function automatic logic writes_result(input logic [4:0] op);
    logic wr;
    if ((op >= OP_NOT) && (op <= OP_LDM)) begin
      wr = 1'b1;
    end else begin
      wr = 1'b0;
    end
    return wr;
  endfunction

  // Opcodes whose result drives Z and N (MOV and LDM deliberately excluded)
  function automatic logic updates_zn(input logic [4:0] op);
    logic upd;
    case (op)
      OP_NOT, OP_INC, OP_DEC,
      OP_ADD, OP_SUB, OP_AND,
      OP_OR,  OP_SHL, OP_SHR: upd = 1'b1;
      default:                upd = 1'b0;
    endcase
    return upd;
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// -----------------------------------------------------------------------------
// execute_stage_if
// Bundle between the decode/execute buffer, the execute stage and the
// execute/memory buffer.
//   Upstream -> stage : Stall, Reg1, Reg2 (W+1 bits, MSB = immediate tag),
//                       Instruction, SrcAddress, RegDestination, FlashNumIn
//   Stage -> downstream: Result, RegDestOut, SrcAddressOut, WriteEn,
//                        Flags ({C,N,Z}), Squashing
// master: the side that drives operands and consumes results.
// slave : the execute stage itself.
// -----------------------------------------------------------------------------
interface execute_stage_if #(
  parameter int W = 16
);

  logic         Stall;
  logic [W:0]   Reg1;
  logic [W:0]   Reg2;
  logic [4:0]   Instruction;
  logic [2:0]   SrcAddress;
  logic [2:0]   RegDestination;
  logic [2:0]   FlashNumIn;

  logic [W-1:0] Result;
  logic [2:0]   RegDestOut;
  logic [2:0]   SrcAddressOut;
  logic         WriteEn;
  logic [2:0]   Flags;
  logic         Squashing;

  modport master (
    output Stall, Reg1, Reg2, Instruction, SrcAddress, RegDestination,
           FlashNumIn,
    input  Result, RegDestOut, SrcAddressOut, WriteEn, Flags, Squashing
  );

  modport slave (
    input  Stall, Reg1, Reg2, Instruction, SrcAddress, RegDestination,
           FlashNumIn,
    output Result, RegDestOut, SrcAddressOut, WriteEn, Flags, Squashing
  );

endinterface

// File: rtl/execute_stage_alu.sv
// -----------------------------------------------------------------------------
// alu
// Purely combinational ALU of the execute stage.
//   op        in  5 : opcode
//   a, b      in  W : operands (immediate tag already stripped)
//   result    out W : ALU result (0 for opcodes with no data result)
//   carry_vld out 1 : this opcode updates C
//   carry_val out 1 : new value of C when carry_vld is high
// -----------------------------------------------------------------------------
module alu
  import mznm_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [4:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         carry_vld,
  output logic         carry_val
);

  logic [W:0] add_ext_s;
  logic [W:0] sub_ext_s;
  logic [W:0] inc_ext_s;
  logic [W:0] dec_ext_s;
  logic [W:0] shl_ext_s;
  logic [W:0] shr_ext_s;
  logic [3:0] shamt_s;

  // Extended-width arithmetic: bit W holds carry (add) or borrow (subtract).
  // Shifts run one bit wider so the last bit shifted out lands in the
  // extension bit: bit W for SHL (= a[W-shamt]), bit 0 for SHR (= a[shamt-1]).
  always_comb begin
    shamt_s   = b[3:0];
    add_ext_s = {1'b0, a} + {1'b0, b};
    sub_ext_s = {1'b0, a} - {1'b0, b};
    inc_ext_s = {1'b0, a} + {{W{1'b0}}, 1'b1};
    dec_ext_s = {1'b0, a} - {{W{1'b0}}, 1'b1};
    shl_ext_s = {1'b0, a} << shamt_s;
    shr_ext_s = {a, 1'b0} >> shamt_s;
  end

  // Opcode select for result and carry
  always_comb begin
    result    = {W{1'b0}};
    carry_vld = 1'b0;
    carry_val = 1'b0;
    case (op)
      OP_SETC: begin
        carry_vld = 1'b1;
        carry_val = 1'b1;
      end
      OP_CLRC: begin
        carry_vld = 1'b1;
        carry_val = 1'b0;
      end
      OP_NOT: result = ~a;
      OP_INC: begin
        result    = inc_ext_s[W-1:0];
        carry_vld = 1'b1;
        carry_val = inc_ext_s[W];
      end
      OP_DEC: begin
        result    = dec_ext_s[W-1:0];
        carry_vld = 1'b1;
        carry_val = dec_ext_s[W];
      end
      OP_MOV: result = a;
      OP_ADD: begin
        result    = add_ext_s[W-1:0];
        carry_vld = 1'b1;
        carry_val = add_ext_s[W];
      end
      OP_SUB: begin
        result    = sub_ext_s[W-1:0];
        carry_vld = 1'b1;
        carry_val = sub_ext_s[W];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_SHL: begin
        result    = shl_ext_s[W-1:0];
        // a shift by zero shifts nothing out, so C keeps its value
        carry_vld = (shamt_s != 4'd0);
        carry_val = shl_ext_s[W];
      end
      OP_SHR: begin
        result    = shr_ext_s[W:1];
        carry_vld = (shamt_s != 4'd0);
        carry_val = shr_ext_s[0];
      end
      OP_LDM: result = b;
      default: begin
        result    = {W{1'b0}};
        carry_vld = 1'b0;
        carry_val = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
// Execute stage of the MZNM pipeline. Every non-stalled rising edge it runs
// the ALU on the latched operands, updates the CCR ({C,N,Z}), advances the
// branch-shadow flush counter and registers the result bundle.
//   Clk   in : clock, all state on the rising edge
//   RstN  in : asynchronous active-low reset
//   bus      : execute_stage_if.slave (operands/opcode in, result bundle out)
// Stall freezes every register, including the CCR and the flush counter.
// Squashed instructions still register Result and the address fields but
// never write the register file or touch the flags.
// -----------------------------------------------------------------------------
module execute_stage
  import mznm_pkg::*;
#(
  parameter int W = 16
) (
  input  logic           Clk,
  input  logic           RstN,
  execute_stage_if.slave bus
);

  logic [W-1:0] op_a_s;
  logic [W-1:0] op_b_s;
  logic [W-1:0] alu_result_s;
  logic         alu_carry_vld_s;
  logic         alu_carry_val_s;
  logic         squash_s;
  logic         unused_tag;

  logic [W-1:0] result_d,    result_q;
  logic [2:0]   reg_dest_d,  reg_dest_q;
  logic [2:0]   src_addr_d,  src_addr_q;
  logic         write_en_d,  write_en_q;
  logic [2:0]   flags_d,     flags_q;
  logic [2:0]   cnt_d,       cnt_q;
  logic         squashing_d, squashing_q;

  // The immediate tag is a decode artefact; the ALU only sees the data bits
  assign op_a_s     = bus.Reg1[W-1:0];
  assign op_b_s     = bus.Reg2[W-1:0];
  assign unused_tag = bus.Reg1[W] ^ bus.Reg2[W];

  alu #(
    .W (W)
  ) u_alu (
    .op        (bus.Instruction),
    .a         (op_a_s),
    .b         (op_b_s),
    .result    (alu_result_s),
    .carry_vld (alu_carry_vld_s),
    .carry_val (alu_carry_val_s)
  );

  // Next-state for the flush counter, CCR and output bundle
  always_comb begin
    result_d    = result_q;
    reg_dest_d  = reg_dest_q;
    src_addr_d  = src_addr_q;
    write_en_d  = write_en_q;
    flags_d     = flags_q;
    cnt_d       = cnt_q;
    squashing_d = squashing_q;
    squash_s    = 1'b0;

    if (bus.Stall) begin
      // hold everything; defaults above already do so
      squash_s = 1'b0;
    end else begin
      squash_s = (cnt_q != 3'd0);

      // A new flush count is only accepted from an empty counter, so a
      // branch inside a shadow cannot extend the shadow.
      if (squash_s) begin
        cnt_d = cnt_q - 3'd1;
      end else if (bus.FlashNumIn != 3'd0) begin
        cnt_d = bus.FlashNumIn;
      end else begin
        cnt_d = 3'd0;
      end
      squashing_d = (cnt_d != 3'd0);

      result_d   = alu_result_s;
      reg_dest_d = bus.RegDestination;
      src_addr_d = bus.SrcAddress;
      write_en_d = (!squash_s) && writes_result(bus.Instruction);

      if (!squash_s) begin
        if (updates_zn(bus.Instruction)) begin
          flags_d[FLG_Z] = (alu_result_s == {W{1'b0}});
          flags_d[FLG_N] = alu_result_s[W-1];
        end else begin
          flags_d[FLG_Z] = flags_q[FLG_Z];
          flags_d[FLG_N] = flags_q[FLG_N];
        end
        if (alu_carry_vld_s) begin
          flags_d[FLG_C] = alu_carry_val_s;
        end else begin
          flags_d[FLG_C] = flags_q[FLG_C];
        end
      end else begin
        flags_d = flags_q;
      end
    end
  end

  // State and output registers
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      result_q    <= {W{1'b0}};
      reg_dest_q  <= 3'd0;
      src_addr_q  <= 3'd0;
      write_en_q  <= 1'b0;
      flags_q     <= 3'b000;
      cnt_q       <= 3'd0;
      squashing_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      reg_dest_q  <= reg_dest_d;
      src_addr_q  <= src_addr_d;
      write_en_q  <= write_en_d;
      flags_q     <= flags_d;
      cnt_q       <= cnt_d;
      squashing_q <= squashing_d;
    end
  end

  assign bus.Result        = result_q;
  assign bus.RegDestOut    = reg_dest_q;
  assign bus.SrcAddressOut = src_addr_q;
  assign bus.WriteEn       = write_en_q;
  assign bus.Flags         = flags_q;
  assign bus.Squashing     = squashing_q;

endmodule

// File: tb/tb_execute_stage.sv
// -----------------------------------------------------------------------------
// tb_execute_stage
// Directed bench for execute_stage (W = 16). Inputs change on the falling
// edge, outputs are compared on the following falling edge.
// Flags are written {C,N,Z}.
// -----------------------------------------------------------------------------
module tb_execute_stage;
  import mznm_pkg::*;

  localparam int W = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  execute_stage_if #(.W(W)) bus ();

  execute_stage #(.W(W)) dut (
    .Clk  (clk),
    .RstN (rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] dst, input logic [2:0] src,
                       input logic [2:0] fl, input logic stall, input logic tag);
    bus.Instruction    = op;
    bus.Reg1           = {1'b0, a};
    bus.Reg2           = {tag, b};
    bus.RegDestination = dst;
    bus.SrcAddress     = src;
    bus.FlashNumIn     = fl;
    bus.Stall          = stall;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic [15:0] res, input logic we,
                            input logic [2:0] flg, input logic sq);
    chk({tag, ".result"}, {16'd0, bus.Result}, {16'd0, res});
    chk({tag, ".we"},     {31'd0, bus.WriteEn}, {31'd0, we});
    chk({tag, ".flags"},  {29'd0, bus.Flags}, {29'd0, flg});
    chk({tag, ".squash"}, {31'd0, bus.Squashing}, {31'd0, sq});
  endtask

  task automatic expect_reset(input string tag);
    chk({tag, ".result"}, {16'd0, bus.Result}, 32'd0);
    chk({tag, ".dst"},    {29'd0, bus.RegDestOut}, 32'd0);
    chk({tag, ".src"},    {29'd0, bus.SrcAddressOut}, 32'd0);
    chk({tag, ".we"},     {31'd0, bus.WriteEn}, 32'd0);
    chk({tag, ".flags"},  {29'd0, bus.Flags}, 32'd0);
    chk({tag, ".squash"}, {31'd0, bus.Squashing}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(OP_ADD, 16'h1234, 16'h1111, 3'd7, 3'd7, 3'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    expect_reset("reset");
    rst_n = 1'b1;

    // ADD wraps to zero: Z and C set
    drive(OP_ADD, 16'hFFFF, 16'h0001, 3'd3, 3'd5, 3'd0, 1'b0, 1'b0);
    cycle();
    expect_out("add", 16'h0000, 1'b1, 3'b101, 1'b0);
    chk("add.dst", {29'd0, bus.RegDestOut}, 32'd3);
    chk("add.src", {29'd0, bus.SrcAddressOut}, 32'd5);

    // SUB 3-5 borrows
    drive(OP_SUB, 16'h0003, 16'h0005, 3'd1, 3'd2, 3'd0, 1'b0, 1'b0);
    cycle();
    expect_out("sub", 16'hFFFE, 1'b1, 3'b110, 1'b0);

    // MOV of zero must not touch Z
    drive(OP_MOV, 16'h0000, 16'h0000, 3'd2, 3'd4, 3'd0, 1'b0, 1'b0);
    cycle();
    expect_out("mov", 16'h0000, 1'b1, 3'b110, 1'b0);

    // SHL by 1: carry = old bit 15
    drive(OP_SHL, 16'h8001, 16'h0001, 3'd1, 3'd1, 3'd0, 1'b0, 1'b0);
    cycle();
    expect_out("shl1", 16'h0002, 1'b1, 3'b100, 1'b0);

    // SHR by 0 keeps C
    drive(OP_SHR, 16'h0001, 16'h0000, 3'd1, 3'd1, 3'd0, 1'b0, 1'b0);
    cycle();
    expect_out("shr0", 16'h0001, 1'b1, 3'b100, 1'b0);

    drive(OP_CLRC, 16'h0000, 16'h0000, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    cycle();
    expect_out("clrc", 16'h0000, 1'b0, 3'b000, 1'b0);

    // SHR by 1: carry = old bit 0
    drive(OP_SHR, 16'h0003, 16'h0001, 3'd1, 3'd1, 3'd0, 1'b0, 1'b0);
    cycle();
    expect_out("shr1", 16'h0001, 1'b1, 3'b100, 1'b0);

    // DEC of zero borrows
    drive(OP_DEC, 16'h0000, 16'h0000, 3'd1, 3'd1, 3'd0, 1'b0, 1'b0);
    cycle();
    expect_out("dec", 16'hFFFF, 1'b1, 3'b110, 1'b0);

    drive(OP_AND, 16'hF0F0, 16'h0FF0, 3'd1, 3'd1, 3'd0, 1'b0, 1'b0);
    cycle();
    expect_out("and", 16'h00F0, 1'b1, 3'b100, 1'b0);

    drive(OP_OR, 16'h8000, 16'h0001, 3'd1, 3'd1, 3'd0, 1'b0, 1'b0);
    cycle();
    expect_out("or", 16'h8001, 1'b1, 3'b110, 1'b0);

    // SHL by 15: carry = old bit 1 (0 here)
    drive(OP_SHL, 16'h0001, 16'h000F, 3'd1, 3'd1, 3'd0, 1'b0, 1'b0);
    cycle();
    expect_out("shl15", 16'h8000, 1'b1, 3'b010, 1'b0);

    drive(OP_NOT, 16'hFFFF, 16'h0000, 3'd1, 3'd1, 3'd0, 1'b0, 1'b0);
    cycle();
    expect_out("not", 16'h0000, 1'b1, 3'b001, 1'b0);

    // LDM with the immediate tag set: tag bit must not reach the result
    drive(OP_LDM, 16'h0000, 16'h1234, 3'd6, 3'd0, 3'd0, 1'b0, 1'b1);
    cycle();
    expect_out("ldm", 16'h1234, 1'b1, 3'b001, 1'b0);

    drive(OP_SETC, 16'h0000, 16'h0000, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    cycle();
    expect_out("setc", 16'h0000, 1'b0, 3'b101, 1'b0);

    // Reserved opcode behaves as NOP
    drive(5'd20, 16'hFFFF, 16'h0001, 3'd1, 3'd1, 3'd0, 1'b0, 1'b0);
    cycle();
    chk("op20.we", {31'd0, bus.WriteEn}, 32'd0);
    chk("op20.flags", {29'd0, bus.Flags}, {29'd0, 3'b101});

    // Branch with a shadow of 2: the branch itself executes
    drive(OP_INC, 16'h0001, 16'h0000, 3'd1, 3'd1, 3'd2, 1'b0, 1'b0);
    cycle();
    expect_out("br", 16'h0002, 1'b1, 3'b000, 1'b1);

    drive(OP_ADD, 16'hFFFF, 16'h0001, 3'd6, 3'd3, 3'd0, 1'b0, 1'b0);
    cycle();
    expect_out("sq1", 16'h0000, 1'b0, 3'b000, 1'b1);
    chk("sq1.dst", {29'd0, bus.RegDestOut}, 32'd6);

    drive(OP_ADD, 16'hFFFF, 16'h0001, 3'd5, 3'd3, 3'd0, 1'b0, 1'b0);
    cycle();
    expect_out("sq2", 16'h0000, 1'b0, 3'b000, 1'b0);

    drive(OP_INC, 16'hFFFF, 16'h0000, 3'd4, 3'd3, 3'd0, 1'b0, 1'b0);
    cycle();
    expect_out("postsq", 16'h0000, 1'b1, 3'b101, 1'b0);

    // Stall for 3 cycles with the counter at 1; FlashNumIn=3 must be ignored
    drive(OP_INC, 16'h0004, 16'h0000, 3'd1, 3'd1, 3'd2, 1'b0, 1'b0);
    cycle();
    expect_out("br2", 16'h0005, 1'b1, 3'b000, 1'b1);

    drive(OP_ADD, 16'h0001, 16'h0001, 3'd2, 3'd2, 3'd0, 1'b0, 1'b0);
    cycle();
    expect_out("sq3", 16'h0002, 1'b0, 3'b000, 1'b1);

    for (int i = 0; i < 3; i++) begin
      drive(OP_ADD, 16'hFFFF, 16'h0001, 3'd7, 3'd7, 3'd3, 1'b1, 1'b0);
      cycle();
      expect_out("stall", 16'h0002, 1'b0, 3'b000, 1'b1);
      chk("stall.dst", {29'd0, bus.RegDestOut}, 32'd2);
    end

    drive(OP_ADD, 16'hFFFF, 16'h0001, 3'd7, 3'd7, 3'd3, 1'b0, 1'b0);
    cycle();
    expect_out("unstall", 16'h0000, 1'b0, 3'b000, 1'b0);

    drive(OP_NOP, 16'h0000, 16'h0000, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    cycle();
    chk("noreload.squash", {31'd0, bus.Squashing}, 32'd0);

    drive(OP_MOV, 16'h0055, 16'h0000, 3'd3, 3'd3, 3'd0, 1'b0, 1'b0);
    cycle();
    expect_out("mov2", 16'h0055, 1'b1, 3'b000, 1'b0);

    // Asynchronous reset between edges while the counter is 2
    drive(OP_INC, 16'h0001, 16'h0000, 3'd5, 3'd6, 3'd2, 1'b0, 1'b0);
    cycle();
    expect_out("br3", 16'h0002, 1'b1, 3'b000, 1'b1);
    rst_n = 1'b0;
    #1;
    expect_reset("areset");
    #2;
    rst_n = 1'b1;
    drive(OP_INC, 16'h0007, 16'h0000, 3'd1, 3'd2, 3'd0, 1'b0, 1'b0);
    cycle();
    expect_out("postrst", 16'h0008, 1'b1, 3'b000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
